// File: rtl/testdrive_clock_gen_multi_if.sv
// -----------------------------------------------------------------------------
// testdrive_clock_gen_multi_if
//   Configuration / output bundle for testdrive_clock_gen_multi.
//
//   Optional macro: TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN adds CYCLE_CNT.
//
//   Signals (C = C_CHANNELS, W = C_DIV_WIDTH):
//     DIV_HALF  [C*W]  per-channel half-period in CLK cycles, 0 = disabled
//     PHASE     [C*W]  per-channel CLK cycles before the first toggle
//     RESTART   [C]    one-cycle pulse: re-latch config and re-run reset
//     CLK_OUT   [C]    divided clocks
//     CLK_EN    [C]    one-cycle pulse where CLK_OUT goes 0->1
//     RST_OUT   [C]    per-channel reset
//     READY     [C]    channel running with its reset released
//     CYCLE_CNT [C*32] (macro only) CLK_EN pulses counted while READY
//
//   Modports: master = testbench side, slave = generator side.
// -----------------------------------------------------------------------------
interface testdrive_clock_gen_multi_if #(
  parameter int C_CHANNELS  = 4,
  parameter int C_DIV_WIDTH = 8
);
  logic [C_CHANNELS*C_DIV_WIDTH-1:0] DIV_HALF;
  logic [C_CHANNELS*C_DIV_WIDTH-1:0] PHASE;
  logic [C_CHANNELS-1:0]             RESTART;
  logic [C_CHANNELS-1:0]             CLK_OUT;
  logic [C_CHANNELS-1:0]             CLK_EN;
  logic [C_CHANNELS-1:0]             RST_OUT;
  logic [C_CHANNELS-1:0]             READY;

`ifdef TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN
  logic [C_CHANNELS*32-1:0]          CYCLE_CNT;

  modport master (output DIV_HALF, PHASE, RESTART,
                  input  CLK_OUT, CLK_EN, RST_OUT, READY, CYCLE_CNT);
  modport slave  (input  DIV_HALF, PHASE, RESTART,
                  output CLK_OUT, CLK_EN, RST_OUT, READY, CYCLE_CNT);
`else
  modport master (output DIV_HALF, PHASE, RESTART,
                  input  CLK_OUT, CLK_EN, RST_OUT, READY);
  modport slave  (input  DIV_HALF, PHASE, RESTART,
                  output CLK_OUT, CLK_EN, RST_OUT, READY);
`endif
endinterface

// File: rtl/testdrive_clock_gen_multi.sv
// -----------------------------------------------------------------------------
// testdrive_clock_gen_multi
//   Derives C_CHANNELS divided clocks from CLK, each with a runtime
//   half-period and phase offset, plus a per-channel reset held for
//   C_RESET_CYCLES divided-clock rising edges and released in ascending
//   channel order.
//
//   Optional macro: TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN adds a per-channel
//   32-bit count of CLK_EN pulses seen while READY.
//
//   Ports:
//     CLK  master clock, all logic on the rising edge
//     RST  synchronous reset, active high
//     bus  testdrive_clock_gen_multi_if.slave (config in, clocks/resets out)
// -----------------------------------------------------------------------------
module testdrive_clock_gen_multi #(
  parameter int C_CHANNELS         = 4,
  parameter int C_DIV_WIDTH        = 8,
  parameter bit C_CLOCK_INIT_VALUE = 1'b0,
  parameter int C_RESET_CYCLES     = 16,
  parameter bit C_RESET_POLARITY   = 1'b0
) (
  input logic                        CLK,
  input logic                        RST,
  testdrive_clock_gen_multi_if.slave bus
);
  localparam int RCNT_W = $clog2(C_RESET_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(C_RESET_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX  = RCNT_W'(C_RESET_CYCLES);

  // Clock FSM
  localparam logic [1:0] CS_LATCH = 2'd0;
  localparam logic [1:0] CS_PHASE = 2'd1;
  localparam logic [1:0] CS_RUN   = 2'd2;
  localparam logic [1:0] CS_OFF   = 2'd3;

  // Reset FSM
  localparam logic [1:0] RS_HOLD      = 2'd0;
  localparam logic [1:0] RS_WAIT_PREV = 2'd1;
  localparam logic [1:0] RS_RELEASED  = 2'd2;

  // Cross-channel view used by the release-ordering chain.
  logic [C_CHANNELS-1:0] ready_v;
  logic [C_CHANNELS-1:0] off_v;

  for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_ch
    logic [1:0]             clk_st;
    logic [1:0]             rst_st;
    logic [C_DIV_WIDTH-1:0] half_q;
    logic [C_DIV_WIDTH-1:0] cnt_q;     // phase countdown, then half-period countdown
    logic [RCNT_W-1:0]      rcnt_q;
    logic                   clk_out_q;
    logic                   clk_en_q;
    logic                   rst_out_q;
    logic                   ready_q;
    logic [C_DIV_WIDTH-1:0] div_in;
    logic [C_DIV_WIDTH-1:0] phase_in;
    logic                   toggle;
    logic                   rise;
    logic                   prev_done;

    assign div_in   = bus.DIV_HALF[gi*C_DIV_WIDTH +: C_DIV_WIDTH];
    assign phase_in = bus.PHASE[gi*C_DIV_WIDTH +: C_DIV_WIDTH];
    assign toggle   = (clk_st == CS_RUN) && (cnt_q == '0);
    assign rise     = toggle && !clk_out_q;

    assign ready_v[gi] = ready_q;
    assign off_v[gi]   = (clk_st == CS_OFF);

    // Ordering only gates the first release: a predecessor counts as done
    // once its reset is released or it is disabled.
    if (gi == 0) begin : g_head
      assign prev_done = 1'b1;
    end else begin : g_chain
      assign prev_done = ready_v[gi-1] | off_v[gi-1];
    end

    // NOTE: every register here uses <= so all channels see each other's
    // pre-edge state, which the ordering chain relies on.
    always_ff @(posedge CLK) begin
      // RST and RESTART reset the channel identically, so RST winning a
      // same-cycle collision needs no special priority.
      if (RST || bus.RESTART[gi]) begin
        clk_st    <= CS_LATCH;
        rst_st    <= RS_HOLD;
        half_q    <= '0;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        clk_out_q <= C_CLOCK_INIT_VALUE;
        clk_en_q  <= 1'b0;
        rst_out_q <= C_RESET_POLARITY;
        ready_q   <= 1'b0;
      end else begin
        clk_en_q <= rise;

        case (clk_st)
          CS_LATCH: begin
            half_q <= div_in;
            if (div_in == '0) begin
              clk_st <= CS_OFF;
            end else if (phase_in == '0) begin
              clk_st <= CS_RUN;
              cnt_q  <= div_in - C_DIV_WIDTH'(1);
            end else begin
              clk_st <= CS_PHASE;
              cnt_q  <= phase_in - C_DIV_WIDTH'(1);
            end
          end
          CS_PHASE: begin
            if (cnt_q == '0) begin
              clk_st <= CS_RUN;
              cnt_q  <= half_q - C_DIV_WIDTH'(1);
            end else begin
              cnt_q <= cnt_q - C_DIV_WIDTH'(1);
            end
          end
          CS_RUN: begin
            // Reload to half-1 on the toggle cycle; half >= 1 here, so
            // the counter never exceeds its width.
            if (toggle) begin
              clk_out_q <= ~clk_out_q;
              cnt_q     <= half_q - C_DIV_WIDTH'(1);
            end else begin
              cnt_q <= cnt_q - C_DIV_WIDTH'(1);
            end
          end
          default: ; // CS_OFF: parked until RESTART or RST
        endcase

        case (rst_st)
          RS_HOLD: begin
            if (rise) begin
              if (rcnt_q != RCNT_MAX) rcnt_q <= rcnt_q + RCNT_W'(1);
              if (rcnt_q == RCNT_LAST) rst_st <= RS_WAIT_PREV;
            end
          end
          RS_WAIT_PREV: begin
            if (prev_done) rst_st <= RS_RELEASED;
          end
          RS_RELEASED: begin
            // Deassert aligned to a divided-clock rising edge.
            if (rise) begin
              rst_out_q <= ~C_RESET_POLARITY;
              ready_q   <= 1'b1;
            end
          end
          default: rst_st <= RS_HOLD;
        endcase
      end
    end

    assign bus.CLK_OUT[gi] = clk_out_q;
    assign bus.CLK_EN[gi]  = clk_en_q;
    assign bus.RST_OUT[gi] = rst_out_q;
    assign bus.READY[gi]   = ready_q;

`ifdef TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge CLK) begin
      if (RST || bus.RESTART[gi]) begin
        cyc_q <= '0;
      end else if (clk_en_q && ready_q) begin
        cyc_q <= cyc_q + 32'd1;  // wraps naturally at 2^32
      end
    end

    assign bus.CYCLE_CNT[gi*32 +: 32] = cyc_q;
`endif
  end
endmodule

// File: tb/tb_testdrive_clock_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_testdrive_clock_gen_multi
//   Self-checking bench for testdrive_clock_gen_multi (2 channels).
//   A timestamp-based reference model predicts every output each cycle;
//   a table of {half, phase} -> {first rise, period} records and a few
//   hand-written sequences cover reset ordering, RESTART and disable.
//   Honours TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_testdrive_clock_gen_multi;
  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam bit INIT = 1'b0;
  localparam int RC   = 16;
  localparam bit POL  = 1'b0;

  logic clk;
  logic rst;

  testdrive_clock_gen_multi_if #(.C_CHANNELS(NCH), .C_DIV_WIDTH(DW)) tdc_if ();

  testdrive_clock_gen_multi #(
    .C_CHANNELS        (NCH),
    .C_DIV_WIDTH       (DW),
    .C_CLOCK_INIT_VALUE(INIT),
    .C_RESET_CYCLES    (RC),
    .C_RESET_POLARITY  (POL)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(tdc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each channel keeps the edge index at which it latched
  // its config; toggles then fall on edges latch + phase + j*half (j >= 1).
  // Reset release is tracked as edge timestamps of the RC-th rise and of the
  // cycle the ordering gate opened.
  // ---------------------------------------------------------------------------
  int          n_edge;
  bit          m_pending [NCH];
  bit          m_off     [NCH];
  int          m_s       [NCH];
  int          m_h       [NCH];
  int          m_p       [NCH];
  int          m_rises   [NCH];
  int          m_hold    [NCH];
  int          m_pass    [NCH];
  bit          m_clk     [NCH];
  bit          m_en      [NCH];
  bit          m_rst     [NCH];
  bit          m_rdy     [NCH];
  int unsigned m_cyc     [NCH];

  task automatic model_step();
    bit old_rdy [NCH];
    bit old_off [NCH];
    bit old_en  [NCH];
    int k;
    bit tog;
    n_edge++;
    for (int i = 0; i < NCH; i++) begin
      old_rdy[i] = m_rdy[i];
      old_off[i] = !m_pending[i] && m_off[i];
      old_en[i]  = m_en[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (rst || tdc_if.RESTART[i]) begin
        m_pending[i] = 1'b1;  m_off[i]  = 1'b0;
        m_clk[i]     = INIT;  m_en[i]   = 1'b0;
        m_rst[i]     = POL;   m_rdy[i]  = 1'b0;
        m_rises[i]   = 0;     m_hold[i] = -1;
        m_pass[i]    = -1;    m_cyc[i]  = 0;
      end else begin
        if (old_en[i] && old_rdy[i]) m_cyc[i]++;
        if (m_pending[i]) begin
          m_pending[i] = 1'b0;
          m_s[i]       = n_edge;
          m_h[i]       = int'(tdc_if.DIV_HALF[i*DW +: DW]);
          m_p[i]       = int'(tdc_if.PHASE[i*DW +: DW]);
          m_off[i]     = (m_h[i] == 0);
        end else if (!m_off[i]) begin
          k       = n_edge - m_s[i] - m_p[i];
          tog     = (k > 0) && (k % m_h[i] == 0);
          m_en[i] = tog && !m_clk[i];
          if (tog) m_clk[i] = !m_clk[i];
          if (m_pass[i] >= 0 && m_en[i] && !m_rdy[i]) begin
            m_rdy[i] = 1'b1;
            m_rst[i] = !POL;
          end
          if (m_hold[i] >= 0 && m_pass[i] < 0 &&
              (i == 0 || old_rdy[i-1] || old_off[i-1]))
            m_pass[i] = n_edge;
          if (m_en[i]) begin
            m_rises[i]++;
            if (m_rises[i] == RC) m_hold[i] = n_edge;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_clk, e_en, e_rst, e_rdy;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i] = m_clk[i];
      e_en[i]  = m_en[i];
      e_rst[i] = m_rst[i];
      e_rdy[i] = m_rdy[i];
    end
    check("clk_out", 64'(tdc_if.CLK_OUT), 64'(e_clk));
    check("clk_en",  64'(tdc_if.CLK_EN),  64'(e_en));
    check("rst_out", 64'(tdc_if.RST_OUT), 64'(e_rst));
    check("ready",   64'(tdc_if.READY),   64'(e_rdy));
`ifdef TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN
    for (int i = 0; i < NCH; i++)
      check("cycle_cnt", 64'(tdc_if.CYCLE_CNT[i*32 +: 32]), 64'(m_cyc[i]));
`endif
  endtask

  // One CLK edge: predict it, then sample the DUT on the following negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    int half;
    int phase;
    int first;   // negedges after RST drops until CLK_OUT[0] is first 1 (0 = never)
    int period;  // CLK cycles between rises (0 = not applicable)
  } vec_t;

  vec_t tbl [5];

  int first, second, r0, r1, en_cnt, last_en, gap, pulses;
  bit prev_clk, en_at_first, bad1, rdy0_seen, rdy1_drop;

  initial begin
    tbl[0] = '{half: 2,   phase: 0, first: 3,   period: 4};
    tbl[1] = '{half: 1,   phase: 0, first: 2,   period: 2};
    tbl[2] = '{half: 3,   phase: 5, first: 9,   period: 6};
    tbl[3] = '{half: 255, phase: 0, first: 256, period: 510};
    tbl[4] = '{half: 0,   phase: 3, first: 0,   period: 0};

    // NOTE: bench inputs are driven with blocking assignments at the negedge,
    // well clear of the edge where the DUT samples them.
    n_edge         = 0;
    rst            = 1'b1;
    tdc_if.DIV_HALF = '0;
    tdc_if.PHASE    = '0;
    tdc_if.RESTART  = '0;

    // --- table: first-rise latency and period of channel 0 ---------------
    for (int t = 0; t < 5; t++) begin
      tdc_if.DIV_HALF = {8'd1, 8'(tbl[t].half)};
      tdc_if.PHASE    = {8'd0, 8'(tbl[t].phase)};
      do_reset(2);
      first = 0; second = 0; prev_clk = INIT; en_at_first = 1'b0;
      for (int c = 1; c <= 1000 && second == 0; c++) begin
        tick();
        if (tdc_if.CLK_OUT[0] && !prev_clk) begin
          if (first == 0) begin
            first       = c;
            en_at_first = tdc_if.CLK_EN[0];
          end else begin
            second = c;
          end
        end
        prev_clk = tdc_if.CLK_OUT[0];
      end
      check($sformatf("tbl%0d_first_rise", t), 64'(first), 64'(tbl[t].first));
      if (tbl[t].period != 0) begin
        check($sformatf("tbl%0d_period", t), 64'(second - first), 64'(tbl[t].period));
        check($sformatf("tbl%0d_en_at_rise", t), 64'(en_at_first), 64'd1);
      end
    end

    // --- A: halves {2,1}, ordered release ---------------------------------
    tdc_if.DIV_HALF = {8'd1, 8'd2};
    tdc_if.PHASE    = '0;
    do_reset(3);
    r0 = 0; r1 = 0; en_cnt = 0; last_en = 0; gap = 0;
    for (int c = 1; c <= 400 && (r0 == 0 || r1 == 0); c++) begin
      tick();
      if (tdc_if.CLK_EN[0]) begin
        if (tdc_if.RST_OUT[0] == POL) en_cnt++;
        if (last_en != 0) gap = c - last_en;
        last_en = c;
      end
      if (r0 == 0 && tdc_if.RST_OUT[0] != POL) r0 = c;
      if (r1 == 0 && tdc_if.RST_OUT[1] != POL) r1 = c;
    end
    check("a_en_while_held", 64'(en_cnt), 64'(RC));
    check("a_en_spacing", 64'(gap), 64'd4);
    check("a_ch0_released", 64'(r0 != 0), 64'd1);
    check("a_ch1_not_before_ch0", 64'(r1 != 0 && r1 >= r0), 64'd1);

    // --- B: RESTART[0] mid-run, repeated while in LATCH, new half 4 --------
    tdc_if.DIV_HALF[7:0] = 8'd3;
    tdc_if.RESTART       = 2'b01;
    tick();
    check("b_rst_out0_asserted", 64'(tdc_if.RST_OUT[0]), 64'(POL));
    check("b_ready0_low", 64'(tdc_if.READY[0]), 64'd0);
    check("b_clk_out0_init", 64'(tdc_if.CLK_OUT[0]), 64'(INIT));
    check("b_ready1_kept", 64'(tdc_if.READY[1]), 64'd1);
    tdc_if.DIV_HALF[7:0] = 8'd4;
    tick();
    tdc_if.RESTART = 2'b00;
    en_cnt = 0; last_en = 0; gap = 0; rdy1_drop = 1'b0;
    for (int c = 1; c <= 600 && !tdc_if.READY[0]; c++) begin
      tick();
      if (!tdc_if.READY[1]) rdy1_drop = 1'b1;
      if (tdc_if.CLK_EN[0]) begin
        if (tdc_if.RST_OUT[0] == POL) en_cnt++;
        if (last_en != 0) gap = c - last_en;
        last_en = c;
      end
    end
    check("b_ready0_after", 64'(tdc_if.READY[0]), 64'd1);
    check("b_en_while_held", 64'(en_cnt), 64'(RC));
    check("b_period8", 64'(gap), 64'd8);
    check("b_ready1_never_dropped", 64'(rdy1_drop), 64'd0);

`ifdef TESTDRIVE_CLOCK_GEN_CYCLE_COUNT_EN
    pulses = 0;
    for (int c = 0; c < 200 && pulses < 10; c++) begin
      if (tdc_if.CLK_EN[0] && tdc_if.READY[0]) pulses++;
      if (pulses < 10) tick();
    end
    tick();
    check("cyc_cnt_after_10", 64'(tdc_if.CYCLE_CNT[31:0]), 64'd10);
    tdc_if.RESTART = 2'b01;
    tick();
    tdc_if.RESTART = 2'b00;
    check("cyc_cnt_cleared", 64'(tdc_if.CYCLE_CNT[31:0]), 64'd0);
`endif

    // --- D: live DIV_HALF change ignored, then RST+RESTART mid-run --------
    repeat (3) tick();
    tdc_if.DIV_HALF[7:0] = 8'd1;
    last_en = 0; gap = 0; pulses = 0;
    for (int c = 1; c <= 100 && pulses < 3; c++) begin
      tick();
      if (tdc_if.CLK_EN[0]) begin
        if (last_en != 0) gap = c - last_en;
        last_en = c;
        pulses++;
      end
    end
    check("d_period_unchanged", 64'(gap), 64'd8);
    rst            = 1'b1;
    tdc_if.RESTART = 2'b11;
    tick();
    check("d_rst_clk_out", 64'(tdc_if.CLK_OUT), 64'({NCH{INIT}}));
    check("d_rst_clk_en", 64'(tdc_if.CLK_EN), 64'd0);
    check("d_rst_rst_out", 64'(tdc_if.RST_OUT), 64'({NCH{POL}}));
    check("d_rst_ready", 64'(tdc_if.READY), 64'd0);
    rst            = 1'b0;
    tdc_if.RESTART = 2'b00;

    // --- C: channel 1 disabled, channel 0 unaffected ---------------------
    tdc_if.DIV_HALF = {8'd0, 8'd2};
    tdc_if.PHASE    = '0;
    do_reset(2);
    bad1 = 1'b0; rdy0_seen = 1'b0;
    repeat (200) begin
      tick();
      if (tdc_if.CLK_OUT[1] != INIT || tdc_if.READY[1] || tdc_if.RST_OUT[1] != POL)
        bad1 = 1'b1;
      if (tdc_if.READY[0]) rdy0_seen = 1'b1;
    end
    check("c_ch1_parked", 64'(bad1), 64'd0);
    check("c_ch0_ready", 64'(rdy0_seen), 64'd1);

    // --- random: live config churn, sparse RESTART / RST ------------------
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NCH; i++) begin
        tdc_if.DIV_HALF[i*DW +: DW] = 8'($urandom_range(0, 6));
        tdc_if.PHASE[i*DW +: DW]    = 8'($urandom_range(0, 7));
      end
      tdc_if.RESTART = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
